// File: rtl/bp_update_sched_if.sv
// Retire-to-update bundle for bp_update_sched.
// master: retire stage / predictor side; slave: the scheduler itself.
interface bp_update_sched_if #(
  parameter int PHT_W = 7,
  parameter int BHT_W = 4,
  parameter int CNT_W = 3
);
  logic             r0_valid;
  logic [PHT_W-1:0] r0_pht_idx;
  logic [BHT_W-1:0] r0_bht_idx;
  logic             r0_taken;
  logic             r1_valid;
  logic [PHT_W-1:0] r1_pht_idx;
  logic [BHT_W-1:0] r1_bht_idx;
  logic             r1_taken;
  logic             retire_ready;
  logic             upd_en;
  logic [PHT_W-1:0] upd_pht_idx;
  logic [BHT_W-1:0] upd_bht_idx;
  logic             upd_taken;
  logic             clr_en;
  logic [PHT_W-1:0] clr_pht_idx;
  logic             clr_bht_en;
  logic [BHT_W-1:0] clr_bht_idx;
  logic             init_busy;
  logic [CNT_W-1:0] q_count;

  modport master (
    output r0_valid, r0_pht_idx, r0_bht_idx, r0_taken,
    output r1_valid, r1_pht_idx, r1_bht_idx, r1_taken,
    input  retire_ready, upd_en, upd_pht_idx, upd_bht_idx, upd_taken,
    input  clr_en, clr_pht_idx, clr_bht_en, clr_bht_idx, init_busy, q_count
  );

  modport slave (
    input  r0_valid, r0_pht_idx, r0_bht_idx, r0_taken,
    input  r1_valid, r1_pht_idx, r1_bht_idx, r1_taken,
    output retire_ready, upd_en, upd_pht_idx, upd_bht_idx, upd_taken,
    output clr_en, clr_pht_idx, clr_bht_en, clr_bht_idx, init_busy, q_count
  );
endinterface

// File: rtl/bp_update_sched.sv
// Branch predictor update scheduler: clears BHT/PHT after reset, then
// serialises up to two retired branch resolutions per cycle into a single
// update per cycle through a small FIFO.
module bp_update_sched #(
  parameter int DEPTH       = 4,
  parameter int PHT_ENTRIES = 128,
  parameter int BHT_ENTRIES = 16,
  parameter int PHT_W       = 7,
  parameter int BHT_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  bp_update_sched_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PHT_W-1:0] PHT_LAST  = PHT_W'(PHT_ENTRIES - 1);
  localparam logic [PHT_W-1:0] BHT_LAST  = PHT_W'(BHT_ENTRIES - 1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic [PHT_W-1:0] pht;
    logic [BHT_W-1:0] bht;
    logic             taken;
  } entry_t;

  state_t           state;
  logic [PHT_W-1:0] sweep_cnt;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             in_run;
  logic             in_init;
  logic             ready;
  logic             push0;
  logic             push1;
  logic             pop;
  logic [CNT_W-1:0] n_push;
  entry_t           r0_entry;
  entry_t           r1_entry;
  entry_t           head_entry;

  // Outputs are forced to zero while reset is held, so state is gated by it.
  assign in_run   = (state == RUN)  && !reset;
  assign in_init  = (state == INIT) && !reset;
  assign ready    = in_run && (count <= READY_MAX);
  assign push0    = bus.r0_valid && ready;
  assign push1    = bus.r1_valid && ready;
  assign pop      = in_run && (count != '0);
  assign n_push   = CNT_W'(push0) + CNT_W'(push1);
  assign r0_entry = {bus.r0_pht_idx, bus.r0_bht_idx, bus.r0_taken};
  assign r1_entry = {bus.r1_pht_idx, bus.r1_bht_idx, bus.r1_taken};
  assign head_entry = mem[head];

  assign bus.retire_ready = ready;
  assign bus.upd_en       = pop;
  assign bus.upd_pht_idx  = pop ? head_entry.pht : '0;
  assign bus.upd_bht_idx  = pop ? head_entry.bht : '0;
  assign bus.upd_taken    = pop && head_entry.taken;
  assign bus.clr_en       = in_init;
  assign bus.clr_pht_idx  = in_init ? sweep_cnt : '0;
  assign bus.clr_bht_en   = in_init && (sweep_cnt <= BHT_LAST);
  assign bus.clr_bht_idx  = in_init ? sweep_cnt[BHT_W-1:0] : '0;
  assign bus.init_busy    = in_init;
  assign bus.q_count      = reset ? '0 : count;

  // Clear-sweep FSM: PHT_ENTRIES cycles of INIT, then RUN until reset.
  // NOTE: all state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else if (state == INIT) begin
      sweep_cnt <= sweep_cnt + PHT_W'(1);
      if (sweep_cnt == PHT_LAST) state <= RUN;
    end
  end

  // Queue pointers and occupancy; one pop per cycle, up to two pushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PTR_W'(1);
      tail  <= tail + PTR_W'(n_push);
      count <= count + n_push - CNT_W'(pop);
    end
  end

  // Queue storage; slot 0 always lands ahead of slot 1 to keep program order.
  // NOTE: storage has no reset; count gates every read so stale data is never issued.
  always_ff @(posedge clk) begin
    if (push0 && push1) begin
      mem[tail]               <= r0_entry;
      mem[tail + PTR_W'(1)]   <= r1_entry;
    end else if (push0) begin
      mem[tail] <= r0_entry;
    end else if (push1) begin
      mem[tail] <= r1_entry;
    end
  end
endmodule

// File: tb/tb_bp_update_sched.sv
// Self-checking bench for bp_update_sched: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_bp_update_sched;
  localparam int DEPTH       = 4;
  localparam int PHT_ENTRIES = 128;
  localparam int BHT_ENTRIES = 16;
  localparam int PHT_W       = 7;
  localparam int BHT_W       = 4;
  localparam int CNT_W       = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  bp_update_sched_if #(.PHT_W(PHT_W), .BHT_W(BHT_W), .CNT_W(CNT_W)) bus ();

  bp_update_sched #(
    .DEPTH(DEPTH), .PHT_ENTRIES(PHT_ENTRIES), .BHT_ENTRIES(BHT_ENTRIES),
    .PHT_W(PHT_W), .BHT_W(BHT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int pht;
    int bht;
    bit taken;
  } upd_t;

  upd_t mq[$];
  bit   m_init  = 1'b1;
  int   m_sweep = 0;

  // Model advance: sweep counts PHT_ENTRIES cycles, then a FIFO that pops
  // one entry per cycle and accepts both slots only when two slots are free.
  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      mq.delete();
      m_init  = 1'b1;
      m_sweep = 0;
    end else if (m_init) begin
      m_sweep++;
      if (m_sweep == PHT_ENTRIES) m_init = 1'b0;
    end else begin
      acc = (DEPTH - mq.size()) >= 2;
      if (mq.size() != 0) void'(mq.pop_front());
      if (acc && bus.r0_valid)
        mq.push_back('{int'(bus.r0_pht_idx), int'(bus.r0_bht_idx), bus.r0_taken});
      if (acc && bus.r1_valid)
        mq.push_back('{int'(bus.r1_pht_idx), int'(bus.r1_bht_idx), bus.r1_taken});
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    bit e_live;
    int e_q;
    e_live = !reset && !m_init;
    e_q    = reset ? 0 : mq.size();
    check("m_retire_ready", bus.retire_ready, e_live && (mq.size() <= DEPTH - 2));
    check("m_upd_en", bus.upd_en, e_live && (mq.size() != 0));
    check("m_q_count", bus.q_count, e_q);
    check("m_init_busy", bus.init_busy, !reset && m_init);
    check("m_clr_en", bus.clr_en, !reset && m_init);
    check("m_clr_pht_idx", bus.clr_pht_idx, (!reset && m_init) ? m_sweep : 0);
    check("m_clr_bht_en", bus.clr_bht_en, !reset && m_init && (m_sweep < BHT_ENTRIES));
    check("m_clr_bht_idx", bus.clr_bht_idx, (!reset && m_init) ? (m_sweep % BHT_ENTRIES) : 0);
    if (e_live && mq.size() != 0) begin
      check("m_upd_pht_idx", bus.upd_pht_idx, mq[0].pht);
      check("m_upd_bht_idx", bus.upd_bht_idx, mq[0].bht);
      check("m_upd_taken", bus.upd_taken, mq[0].taken);
    end else if (reset) begin
      check("m_rst_upd_pht", bus.upd_pht_idx, 0);
      check("m_rst_upd_bht", bus.upd_bht_idx, 0);
      check("m_rst_upd_taken", bus.upd_taken, 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input bit v0, input int p0, input int b0, input bit t0,
                        input bit v1, input int p1, input int b1, input bit t1);
    bus.r0_valid   = v0;
    bus.r0_pht_idx = PHT_W'(p0);
    bus.r0_bht_idx = BHT_W'(b0);
    bus.r0_taken   = t0;
    bus.r1_valid   = v1;
    bus.r1_pht_idx = PHT_W'(p1);
    bus.r1_bht_idx = BHT_W'(b1);
    bus.r1_taken   = t1;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_in();
    set_in(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs a full sweep starting at the current cycle with random retire traffic,
  // checking the clear pattern literally and that nothing is issued.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < PHT_ENTRIES; i++) begin
      rand_in();
      @(negedge clk);
      check({tag, "_clr_en"}, bus.clr_en, 1);
      check({tag, "_clr_idx"}, bus.clr_pht_idx, i);
      check({tag, "_bht_en"}, bus.clr_bht_en, (i < BHT_ENTRIES) ? 1 : 0);
      if (i < BHT_ENTRIES) check({tag, "_bht_idx"}, bus.clr_bht_idx, i);
      check({tag, "_no_upd"}, bus.upd_en, 0);
      check({tag, "_not_ready"}, bus.retire_ready, 0);
      step();
    end
    idle();
    @(negedge clk);
    check({tag, "_busy_fall"}, bus.init_busy, 0);
    check({tag, "_ready_rise"}, bus.retire_ready, 1);
    check({tag, "_clr_off"}, bus.clr_en, 0);
    check({tag, "_q_empty"}, bus.q_count, 0);
    step();
  endtask

  // Watchdog: the run is fixed-length, so this only fires on a simulator hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  bit pat [6] = '{1, 1, 0, 1, 0, 1};

  initial begin
    int issued;
    idle();
    reset = 1'b1;
    step();
    step();
    check("rst_ready", bus.retire_ready, 0);
    check("rst_busy", bus.init_busy, 0);
    reset = 1'b0;

    // Clear sweep after power-on reset.
    sweep_check("sweep0");

    // Single latency: push at N, issue at N+1 only.
    set_in(1, 'h25, 'h9, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("lat_q_before", bus.q_count, 0);
    check("lat_no_bypass", bus.upd_en, 0);
    step();
    idle();
    @(negedge clk);
    check("lat_upd_en", bus.upd_en, 1);
    check("lat_pht", bus.upd_pht_idx, 'h25);
    check("lat_bht", bus.upd_bht_idx, 'h9);
    check("lat_taken", bus.upd_taken, 1);
    check("lat_q1", bus.q_count, 1);
    step();
    @(negedge clk);
    check("lat_upd_off", bus.upd_en, 0);
    check("lat_q0", bus.q_count, 0);
    step();

    // Dual push: r0 issues before r1.
    set_in(1, 'h01, 'h1, 0, 1, 'h02, 'h2, 1);
    step();
    idle();
    @(negedge clk);
    check("dual_q2", bus.q_count, 2);
    check("dual_pht0", bus.upd_pht_idx, 'h01);
    check("dual_taken0", bus.upd_taken, 0);
    step();
    @(negedge clk);
    check("dual_q1", bus.q_count, 1);
    check("dual_pht1", bus.upd_pht_idx, 'h02);
    check("dual_bht1", bus.upd_bht_idx, 'h2);
    check("dual_taken1", bus.upd_taken, 1);
    step();
    @(negedge clk);
    check("dual_q0", bus.q_count, 0);
    check("dual_upd_off", bus.upd_en, 0);
    step();

    // r1 only.
    set_in(0, 0, 0, 0, 1, 'h7F, 'hF, 1);
    step();
    idle();
    @(negedge clk);
    check("r1_upd_en", bus.upd_en, 1);
    check("r1_pht", bus.upd_pht_idx, 'h7F);
    check("r1_bht", bus.upd_bht_idx, 'hF);
    check("r1_taken", bus.upd_taken, 1);
    step();
    @(negedge clk);
    check("r1_upd_off", bus.upd_en, 0);
    step();

    // Backpressure and wrap: two per cycle for 6 cycles, then drain.
    issued = 0;
    for (int i = 0; i < 6; i++) begin
      set_in(1, int'($urandom_range(0, 127)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             1, int'($urandom_range(0, 127)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      check("bp_ready", bus.retire_ready, pat[i]);
      check("bp_qmax", (bus.q_count <= DEPTH) ? 1 : 0, 1);
      if (bus.upd_en) issued++;
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.upd_en) issued++;
      step();
    end
    check("bp_issued", issued, 8);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      rand_in();
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) step();

    // Reset with three entries queued.
    set_in(1, 'h10, 'h3, 1, 1, 'h11, 'h4, 0);
    step();
    set_in(1, 'h12, 'h5, 1, 1, 'h13, 'h6, 1);
    step();
    idle();
    @(negedge clk);
    check("mid_q3", bus.q_count, 3);
    #1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("mid_clr_idx", bus.clr_pht_idx, i);
      check("mid_no_upd", bus.upd_en, 0);
      check("mid_q_empty", bus.q_count, 0);
      step();
    end

    // Reset again at sweep count 40; the sweep restarts from 0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    sweep_check("sweep2");

    for (int i = 0; i < 50; i++) begin
      rand_in();
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
